// File: rtl/ins_frame_sched.sv
`default_nettype none
// ============================================================================
// Module  : ins_frame_sched
// Purpose : Round-robin share of the 12-bit I2C instruction-frame builder;
//           checks the returned frame and shifts it out LSB first.
// Rev     : 1.0
// ============================================================================
module ins_frame_sched #(
   parameter int         NREQ       = 4,
   parameter logic [3:0] SLAVE_ADDR = 4'b0010,
   parameter int         TIMEOUT    = 4
) (
   input  logic              clkins,
   input  logic              rstins,
   input  logic [NREQ-1:0]   req,
   input  logic [4*NREQ-1:0] req_ins,
   output logic [NREQ-1:0]   gnt,
   output logic [NREQ-1:0]   done,
   output logic              err,
   output logic              busy,
   output logic              startins,
   output logic [3:0]        addins,
   output logic [3:0]        ins,
   input  logic [11:0]       inssend,
   output logic              sda_out,
   output logic              sda_oe
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   localparam logic [2:0] c_st_idle  = 3'd0;
   localparam logic [2:0] c_st_issue = 3'd1;
   localparam logic [2:0] c_st_wait  = 3'd2;
   localparam logic [2:0] c_st_shift = 3'd3;
   localparam logic [2:0] c_st_done  = 3'd4;

   localparam logic [3:0]    c_wait_last = 4'(TIMEOUT - 1);
   localparam logic [3:0]    c_bit_last  = 4'd11;
   localparam logic [PW-1:0] c_ptr_rst   = PW'(NREQ - 1);

   logic [2:0]      r_state;
   logic [PW-1:0]   r_ptr;
   logic [PW-1:0]   r_win;
   logic [3:0]      r_nib;
   logic [3:0]      r_wait_cnt;
   logic [3:0]      r_bit_cnt;
   logic [11:0]     r_shreg;

   int              w_sum;
   logic [PW-1:0]   w_cand;
   logic [PW-1:0]   w_pick;
   logic [3:0]      w_pick_nib;
   logic [NREQ-1:0] w_win_1h;
   logic [11:0]     w_frame_exp;
   logic            w_frame_ok;
   logic            w_timeout;

   // Scan from ptr+NREQ down to ptr+1 so the last hit is the closest to ptr+1.
   always_comb begin
      w_sum  = 0;
      w_cand = '0;
      w_pick = c_ptr_rst;
      for (int i = NREQ; i >= 1; i--) begin
         w_sum = int'(r_ptr) + i;
         if (w_sum >= NREQ) begin
            w_sum = w_sum - NREQ;
         end
         w_cand = w_sum[PW-1:0];
         if (req[w_cand]) begin
            w_pick = w_cand;
         end
      end
   end

   always_comb begin
      w_pick_nib = 4'b0000;
      w_win_1h   = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (w_pick == PW'(k)) begin
            w_pick_nib = req_ins[4*k +: 4];
         end
         w_win_1h[k] = (r_win == PW'(k));
      end
   end

   // Any unknown bit from the builder disqualifies the frame.
   assign w_frame_exp = {2'b11, 4'b0000, r_nib, 2'b11};
   assign w_frame_ok  = !$isunknown(inssend) && (inssend == w_frame_exp);
   assign w_timeout   = (r_state == c_st_wait) && !w_frame_ok &&
                        (r_wait_cnt == c_wait_last);

   always_ff @(posedge clkins) begin
      if (rstins) begin
         r_state    <= c_st_idle;
         r_ptr      <= c_ptr_rst;
         r_win      <= '0;
         r_nib      <= 4'b0000;
         r_wait_cnt <= 4'd0;
         r_bit_cnt  <= 4'd0;
         r_shreg    <= 12'd0;
      end else begin
         case (r_state)
            c_st_idle: begin
               if (|req) begin
                  r_win   <= w_pick;
                  r_nib   <= w_pick_nib;
                  r_state <= c_st_issue;
               end
            end
            c_st_issue: begin
               r_wait_cnt <= 4'd0;
               r_state    <= c_st_wait;
            end
            c_st_wait: begin
               if (w_frame_ok) begin
                  r_shreg   <= inssend;
                  r_bit_cnt <= 4'd0;
                  r_state   <= c_st_shift;
               end else if (w_timeout) begin
                  r_ptr   <= r_win;
                  r_state <= c_st_idle;
               end else begin
                  r_wait_cnt <= r_wait_cnt + 4'd1;
               end
            end
            c_st_shift: begin
               r_shreg <= {1'b0, r_shreg[11:1]};
               if (r_bit_cnt == c_bit_last) begin
                  r_state <= c_st_done;
               end else begin
                  r_bit_cnt <= r_bit_cnt + 4'd1;
               end
            end
            c_st_done: begin
               r_ptr   <= r_win;
               r_state <= c_st_idle;
            end
            default: begin
               r_state <= c_st_idle;
            end
         endcase
      end
   end

   always_comb begin
      gnt      = '0;
      done     = '0;
      err      = 1'b0;
      busy     = (r_state != c_st_idle);
      startins = 1'b0;
      addins   = 4'b0000;
      ins      = 4'b0000;
      sda_out  = 1'b0;
      sda_oe   = 1'b0;
      case (r_state)
         c_st_issue: begin
            gnt      = w_win_1h;
            startins = 1'b1;
            addins   = SLAVE_ADDR;
            ins      = r_nib;
         end
         c_st_wait: begin
            startins = 1'b1;
            addins   = SLAVE_ADDR;
            ins      = r_nib;
            err      = w_timeout;
         end
         c_st_shift: begin
            sda_oe  = 1'b1;
            sda_out = r_shreg[0];
         end
         c_st_done: begin
            done = w_win_1h;
         end
         default: begin
         end
      endcase
   end

endmodule
`default_nettype wire
